// File: rtl/riscv_ifetch.sv
// Instruction fetch: PC sequencer feeding a 2-entry {pc, inst} queue to decode.
// Redirects flush the queue and restart fetch at a word-aligned target.
module riscv_ifetch #(
  parameter int unsigned XLEN          = 32,
  parameter int unsigned IMEM_ADDR_BIT = 12,
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  output logic [IMEM_ADDR_BIT-3:0] o_imem_addr,
  input  logic [XLEN-1:0]          i_imem_data,
  input  logic                     i_redirect,
  input  logic [XLEN-1:0]          i_redirect_pc,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [XLEN-1:0]          o_inst,
  output logic [XLEN-1:0]          o_pc
);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [1:0]      count_q, count_d;
  logic            rd_ptr_q, rd_ptr_d;
  logic            wr_ptr_q, wr_ptr_d;
  logic [XLEN-1:0] q_pc_q   [2];
  logic [XLEN-1:0] q_pc_d   [2];
  logic [XLEN-1:0] q_inst_q [2];
  logic [XLEN-1:0] q_inst_d [2];
  logic            push, pop;

  assign o_imem_addr = fetch_pc_q[IMEM_ADDR_BIT-1:2];
  assign o_valid     = (count_q != 2'd0);
  assign o_pc        = o_valid ? q_pc_q[rd_ptr_q]   : '0;
  assign o_inst      = o_valid ? q_inst_q[rd_ptr_q] : '0;

  always_comb begin
    pop        = o_valid && i_ready && !i_redirect;
    push       = !i_redirect && ((count_q != 2'd2) || pop);
    fetch_pc_d = fetch_pc_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    q_pc_d     = q_pc_q;
    q_inst_d   = q_inst_q;
    if (i_redirect) begin
      // Flush wins over any push/pop this cycle; low bits dropped silently.
      fetch_pc_d = i_redirect_pc & ~XLEN'(3);
      count_d    = 2'd0;
      rd_ptr_d   = 1'b0;
      wr_ptr_d   = 1'b0;
    end else begin
      if (push) begin
        q_pc_d[wr_ptr_q]   = fetch_pc_q;
        q_inst_d[wr_ptr_q] = i_imem_data;
        wr_ptr_d           = ~wr_ptr_q;
        fetch_pc_d         = fetch_pc_q + XLEN'(4);
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      fetch_pc_q  <= RESET_PC;
      count_q     <= 2'd0;
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
      q_pc_q[0]   <= '0;
      q_pc_q[1]   <= '0;
      q_inst_q[0] <= '0;
      q_inst_q[1] <= '0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      q_pc_q[0]   <= q_pc_d[0];
      q_pc_q[1]   <= q_pc_d[1];
      q_inst_q[0] <= q_inst_d[0];
      q_inst_q[1] <= q_inst_d[1];
    end
  end

endmodule

// File: tb/tb_riscv_ifetch.sv
// Directed bench for riscv_ifetch; memory word[n] = n, so inst = pc[11:2].
// Outputs are sampled on the falling edge, inputs change there too.
module tb_riscv_ifetch;

  logic        clk;
  logic        rst;
  logic [9:0]  imem_addr;
  logic [31:0] imem_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        valid;
  logic        ready;
  logic [31:0] inst;
  logic [31:0] pc;

  int vectors;
  int errors;
  int accepted;
  logic [31:0] exp_pc;

  riscv_ifetch dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .o_imem_addr  (imem_addr),
    .i_imem_data  (imem_data),
    .i_redirect   (redirect),
    .i_redirect_pc(redirect_pc),
    .o_valid      (valid),
    .i_ready      (ready),
    .o_inst       (inst),
    .o_pc         (pc)
  );

  assign imem_data = {22'h0, imem_addr};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic nx();
    @(negedge clk);
  endtask

  task automatic chk_head(input string tag, input logic [31:0] epc);
    chk({tag, "_valid"}, {31'h0, valid}, 32'd1);
    chk({tag, "_pc"}, pc, epc);
    chk({tag, "_inst"}, inst, {22'h0, epc[11:2]});
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, "_valid"}, {31'h0, valid}, 32'd0);
    chk({tag, "_pc"}, pc, 32'h0);
    chk({tag, "_inst"}, inst, 32'h0);
  endtask

  initial begin
    vectors     = 0;
    errors      = 0;
    accepted    = 0;
    rst         = 1'b1;
    ready       = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 32'h0;

    // reset state and streaming at one instruction per cycle
    nx();
    nx();
    chk_empty("rst");
    chk("rst_addr", {22'h0, imem_addr}, 32'h0);
    rst = 1'b0;
    #1;
    chk("rel_valid", {31'h0, valid}, 32'd0);
    nx();
    chk_head("s1_0", 32'h0);
    nx();
    chk_head("s1_1", 32'h4);
    nx();
    chk_head("s1_2", 32'h8);

    // stall: queue fills to 2, fetch_pc stops at 8
    rst   = 1'b1;
    ready = 1'b0;
    #1;
    chk_empty("rst2");
    nx();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      nx();
      chk_head("stall", 32'h0);
    end
    chk("stall_addr", {22'h0, imem_addr}, 32'h2);
    ready = 1'b1;
    nx();
    chk_head("drain_1", 32'h4);
    nx();
    chk_head("drain_2", 32'h8);
    nx();
    chk_head("drain_3", 32'hC);

    // redirect with full queue and ready high
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0103;
    nx();
    chk_empty("redir_flush");
    chk("redir_addr", {22'h0, imem_addr}, 32'h40);
    redirect = 1'b0;
    nx();
    chk_head("redir_0", 32'h100);
    nx();
    chk_head("redir_1", 32'h104);

    // PC wrap at top of address space
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFE;
    nx();
    chk_empty("wrap_flush");
    chk("wrap_addr", {22'h0, imem_addr}, 32'h3FF);
    redirect = 1'b0;
    nx();
    chk_head("wrap_0", 32'hFFFF_FFFC);
    nx();
    chk_head("wrap_1", 32'h0);

    // async reset pulse between edges with a full queue
    redirect    = 1'b1;
    redirect_pc = 32'h200;
    ready       = 1'b0;
    nx();
    redirect = 1'b0;
    nx();
    chk_head("fill_1", 32'h200);
    nx();
    chk_head("fill_2", 32'h200);
    rst = 1'b1;
    #2;
    chk_empty("arst");
    chk("arst_addr", {22'h0, imem_addr}, 32'h0);
    rst   = 1'b0;
    ready = 1'b1;
    nx();
    chk_head("resume_0", 32'h0);
    nx();
    chk_head("resume_1", 32'h4);

    // random ready and redirects against a PC-sequence model
    for (int i = 0; i < 300; i++) begin
      ready    = ($urandom_range(0, 3) != 0);
      redirect = (i == 0) || ($urandom_range(0, 9) == 0);
      redirect_pc = (i == 0) ? 32'h0000_0FF6 : $urandom;
      #1;
      if (valid && ready && !redirect) begin
        chk("rnd_pc", pc, exp_pc);
        chk("rnd_inst", inst, {22'h0, exp_pc[11:2]});
        exp_pc = exp_pc + 32'd4;
        accepted++;
      end
      if (redirect) exp_pc = redirect_pc & ~32'h3;
      nx();
    end
    redirect = 1'b0;
    chk("rnd_progress", {31'h0, (accepted > 50)}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
